// File: rtl/isqrt_sched_pkg.sv
// Shared types and helpers for the inverse-square-root scheduler and
// other shared ALU units.
package isqrt_sched_pkg;

  localparam int TAG_MAX   = 8;
  localparam int SAT_MAX_W = 64;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shadow stage record. The tag field is sized for the widest supported
  // requester count; users keep only the low TAGW bits.
  typedef struct packed {
    logic               v;
    logic [TAG_MAX-1:0] tag;
    logic               err;
  } shd_stage_t;

  // Largest positive value in a w-bit two's complement field: sign clear,
  // all other bits set.
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
    return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/isqrt_sched_if.sv
// Requester and result ports of the inverse-square-root scheduler.
// Handshake: a word moves on a rising edge when valid and ready are both 1;
// valid and data are held stable by the sender until that edge.
interface isqrt_sched_if
  import isqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4,
  parameter int WIO  = WF,
  parameter int WFO  = WI,
  parameter int TAGW = tag_w(NREQ)
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*(WI+WF)-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [WIO+WFO-1:0]      res_data;
  logic [TAGW-1:0]         res_tag;
  logic                    res_err;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_tag, res_err
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_tag, res_err
  );

endinterface

// File: rtl/isqrt_sched_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr_i with wrap, grants the first
// requester, and returns the pointer to use after this cycle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          adv_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic [IW-1:0] ptr_nxt_o
);

  always_comb begin
    idx_o     = '0;
    any_o     = 1'b0;
    grant_o   = '0;
    ptr_nxt_o = ptr_i;
    // Walking downward lets the lowest offset from ptr_i win.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o = IW'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    end
    if (any_o && adv_i) begin
      grant_o[idx_o] = 1'b1;
      ptr_nxt_o      = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/isqrt_sched.sv
// Shares one pipelined inverse-square-root core among NREQ requesters and
// returns tagged results in issue order on a back-pressured port.
module isqrt_sched
  import isqrt_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WI       = 4,
  parameter int WF       = 4,
  parameter int WIO      = WF,
  parameter int WFO      = WI,
  parameter int CORE_LAT = 3,
  parameter int TAGW     = tag_w(NREQ)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  isqrt_sched_if.slave         bus,
  output logic                 core_ce,
  output logic [WI+WF-1:0]     core_din,
  input  logic [WIO+WFO-1:0]   core_dout
);

  localparam int W_IN  = WI + WF;
  localparam int W_OUT = WIO + WFO;

  logic              adv;
  logic              xfer;
  logic [NREQ-1:0]   grant;
  logic [TAGW-1:0]   g_idx;
  logic              g_any;
  logic [W_IN-1:0]   g_op;
  logic [TAGW-1:0]   ptr_q, ptr_d;
  shd_stage_t        shd_in;
  shd_stage_t        shd_last;
  shd_stage_t        shd_q [CORE_LAT];
  logic              res_valid_q;
  logic [W_OUT-1:0]  res_data_q, res_data_d;
  logic [TAGW-1:0]   res_tag_q;
  logic              res_err_q;

  // Everything, core included, advances only when the output slot can take
  // a new value; reset forces the enable low so nothing is granted.
  assign adv     = nRST && (!res_valid_q || bus.res_ready);
  assign core_ce = adv;

  rr_arbiter #(
    .N  (NREQ),
    .IW (TAGW)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .adv_i     (adv),
    .grant_o   (grant),
    .idx_o     (g_idx),
    .any_o     (g_any),
    .ptr_nxt_o (ptr_d)
  );

  assign xfer          = g_any && adv;
  assign g_op          = bus.req_data[g_idx*W_IN +: W_IN];
  assign core_din      = g_any ? g_op : '0;
  assign bus.req_ready = grant;

  always_comb begin
    shd_in.v   = xfer;
    shd_in.tag = TAG_MAX'(g_idx);
    shd_in.err = xfer && (g_op == '0);
  end

  assign shd_last = shd_q[CORE_LAT-1];

  // A zero operand has no finite result; report the largest positive value.
  always_comb begin
    res_data_d = res_data_q;
    if (shd_last.v) begin
      res_data_d = shd_last.err ? W_OUT'(sat_max(W_OUT)) : core_dout;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q       <= '0;
      for (int s = 0; s < CORE_LAT; s++) shd_q[s] <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else if (adv) begin
      ptr_q    <= ptr_d;
      shd_q[0] <= shd_in;
      for (int s = 1; s < CORE_LAT; s++) shd_q[s] <= shd_q[s-1];
      res_valid_q <= shd_last.v;
      res_data_q  <= res_data_d;
      res_tag_q   <= shd_last.tag[TAGW-1:0];
      res_err_q   <= shd_last.err;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_isqrt_sched.sv
// Self-checking bench for isqrt_sched with a behavioural pipelined core and
// a scoreboard of expected {err, tag, data} results.
module tb_isqrt_sched;
  import isqrt_sched_pkg::*;

  localparam int NREQ     = 4;
  localparam int WI       = 4;
  localparam int WF       = 4;
  localparam int WIO      = 4;
  localparam int WFO      = 4;
  localparam int CORE_LAT = 3;
  localparam int TAGW     = 2;
  localparam int W        = WI + WF;
  localparam int WO       = WIO + WFO;
  localparam int SBW      = 1 + TAGW + WO;
  localparam logic [WO-1:0] SAT = {1'b0, {(WO-1){1'b1}}};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  isqrt_sched_if #(.NREQ(NREQ), .WI(WI), .WF(WF), .WIO(WIO), .WFO(WFO), .TAGW(TAGW)) bus ();

  logic          core_ce;
  logic [W-1:0]  core_din;
  logic [WO-1:0] core_dout;
  logic [WO-1:0] core_pipe [CORE_LAT];

  isqrt_sched #(
    .NREQ(NREQ), .WI(WI), .WF(WF), .WIO(WIO), .WFO(WFO), .CORE_LAT(CORE_LAT), .TAGW(TAGW)
  ) u_dut (
    .CLK       (clk),
    .nRST      (rst_n),
    .bus       (bus),
    .core_ce   (core_ce),
    .core_din  (core_din),
    .core_dout (core_dout)
  );

  // ---------------- reference arithmetic ----------------
  // Largest r with (r/16)^2 * (x/16) <= 1, i.e. floor of 1/sqrt(x) in Q4.4.
  function automatic logic [WO-1:0] isqrt_ref(input logic [W-1:0] x);
    int r = 0;
    for (int c = 1; c < (1 << WO); c++)
      if (c * c * int'(x) <= (1 << (2*WFO + WF))) r = c;
    return WO'(r);
  endfunction

  // Core behaviour: zero gives junk the scheduler must override; negative
  // inputs give a marker value.
  function automatic logic [WO-1:0] core_fn(input logic [W-1:0] x);
    if (x == '0) return '0;
    if (x[W-1]) return 8'hA5;
    return isqrt_ref(x);
  endfunction

  function automatic logic [SBW-1:0] exp_entry(input int tag, input logic [W-1:0] x);
    logic [TAGW-1:0] t = TAGW'(tag);
    if (x == '0) return {1'b1, t, SAT};
    return {1'b0, t, core_fn(x)};
  endfunction

  always @(posedge clk) begin
    if (core_ce) begin
      core_pipe[0] <= core_fn(core_din);
      for (int s = 1; s < CORE_LAT; s++) core_pipe[s] <= core_pipe[s-1];
    end
  end
  assign core_dout = core_pipe[CORE_LAT-1];

  // ---------------- scoreboard / monitor ----------------
  logic [SBW-1:0]  exp_q[$];
  logic [SBW-1:0]  got_q[$];
  int              got_cyc_q[$];
  int              gnt_q[$];
  logic [NREQ-1:0] gvec_q[$];
  int              acc_total, res_total, cyc;
  int              n_checks, n_errors;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back(exp_entry(i, bus.req_data[i*W +: W]));
          gnt_q.push_back(i);
          gvec_q.push_back(bus.req_valid);
          acc_total++;
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        got_q.push_back({bus.res_err, bus.res_tag, bus.res_data});
        got_cyc_q.push_back(cyc);
        res_total++;
      end
    end
  end

  // ---------------- driver ----------------
  logic [W-1:0] op_q [NREQ][$];
  int           gap  [NREQ];
  int           hold [NREQ];
  int           rdy_mode;

  task automatic clear_tb_state();
    for (int i = 0; i < NREQ; i++) begin
      op_q[i].delete();
      gap[i]  = 1;
      hold[i] = 0;
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    gnt_q.delete(); gvec_q.delete();
    acc_total = 0;
    res_total = 0;
    rdy_mode  = 0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    clear_tb_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.res_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        op_q[i].delete(0);
        bus.req_valid[i] = 1'b0;
        hold[i] = gap[i] - 1;
      end else if (hold[i] > 0) begin
        hold[i]--;
      end
      if (!bus.req_valid[i] && hold[i] == 0 && op_q[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*W +: W]  = op_q[i][0];
      end
    end
  endtask

  task automatic drive_done(input int max_cycles);
    bit done = 1'b0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      drive_step();
      done = (bus.req_valid == '0) && (res_total == acc_total);
      for (int i = 0; i < NREQ; i++) if (op_q[i].size() != 0) done = 1'b0;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL drain_timeout: accepted %0d returned %0d after %0d cycles", acc_total, res_total, max_cycles);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_data  = {NREQ{8'h40}};
    bus.res_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %0b want 0", bus.res_valid); end
    n_checks++; if (bus.res_data !== '0) begin n_errors++; $display("FAIL reset_res_data: got %0h want 0", bus.res_data); end
    n_checks++; if (bus.res_tag !== '0) begin n_errors++; $display("FAIL reset_res_tag: got %0d want 0", bus.res_tag); end
    n_checks++; if (bus.res_err !== 1'b0) begin n_errors++; $display("FAIL reset_res_err: got %0b want 0", bus.res_err); end
    n_checks++; if (core_ce !== 1'b0) begin n_errors++; $display("FAIL reset_core_ce: got %0b want 0", core_ce); end
    n_checks++; if (bus.req_ready !== '0) begin n_errors++; $display("FAIL reset_req_ready: got %0b want 0", bus.req_ready); end
    do_reset();
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    bus.res_ready           = 1'b1;
    bus.req_valid[2]        = 1'b1;
    bus.req_data[2*W +: W]  = 8'h40;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_grant: got %b want 0100", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.res_valid) break;
    end
    n_checks++; if (n !== CORE_LAT + 1) begin n_errors++; $display("FAIL single_latency: got %0d want %0d", n, CORE_LAT + 1); end
    n_checks++; if (bus.res_data !== 8'h08) begin n_errors++; $display("FAIL single_data: got %0h want 08", bus.res_data); end
    n_checks++; if (bus.res_tag !== 2'd2) begin n_errors++; $display("FAIL single_tag: got %0d want 2", bus.res_tag); end
    n_checks++; if (bus.res_err !== 1'b0) begin n_errors++; $display("FAIL single_err: got %0b want 0", bus.res_err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) repeat (4) op_q[i].push_back(8'h10);
    drive_done(200);
    n_checks++; if (gnt_q.size() != 16 || got_q.size() != 16) begin
      n_errors++; $display("FAIL rr_count: grants %0d results %0d want 16", gnt_q.size(), got_q.size());
    end
    for (int k = 0; k < 16 && k < gnt_q.size() && k < got_q.size(); k++) begin
      n_checks++; if (gnt_q[k] != k % NREQ) begin n_errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, gnt_q[k], k % NREQ); end
      n_checks++; if (got_q[k] !== {1'b0, TAGW'(k % NREQ), 8'h10}) begin
        n_errors++; $display("FAIL rr_result[%0d]: got %0h want %0h", k, got_q[k], {1'b0, TAGW'(k % NREQ), 8'h10});
      end
      if (k > 0) begin
        n_checks++; if (got_cyc_q[k] - got_cyc_q[k-1] != 1) begin
          n_errors++; $display("FAIL rr_throughput[%0d]: gap %0d want 1", k, got_cyc_q[k] - got_cyc_q[k-1]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [SBW:0] snap;
    int           per_tag [NREQ];
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      per_tag[i] = 0;
      repeat (6) op_q[i].push_back(8'($urandom_range(1, 127)));
    end
    repeat (8) drive_step();
    n_checks++; if (bus.res_valid !== 1'b1) begin n_errors++; $display("FAIL bp_streaming: res_valid %0b want 1", bus.res_valid); end
    bus.res_ready = 1'b0;
    @(negedge clk);
    snap = {bus.res_valid, bus.res_err, bus.res_tag, bus.res_data};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++; if (core_ce !== 1'b0) begin n_errors++; $display("FAIL bp_core_ce[%0d]: got %0b want 0", c, core_ce); end
      n_checks++; if (bus.req_ready !== '0) begin n_errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", c, bus.req_ready); end
      n_checks++; if ({bus.res_valid, bus.res_err, bus.res_tag, bus.res_data} !== snap) begin
        n_errors++; $display("FAIL bp_res_stable[%0d]: got %0h want %0h", c, {bus.res_valid, bus.res_err, bus.res_tag, bus.res_data}, snap);
      end
      @(posedge clk); #1;
    end
    drive_done(300);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL bp_result[%0d]: got %0h want %0h", k, got_q[k], exp_q[k]); end
    end
    foreach (got_q[k]) per_tag[int'(got_q[k][WO +: TAGW])]++;
    for (int i = 0; i < NREQ; i++) begin
      n_checks++; if (per_tag[i] != 6) begin n_errors++; $display("FAIL bp_tag_count[%0d]: got %0d want 6", i, per_tag[i]); end
    end
  endtask

  task automatic test_zero_operand();
    do_reset();
    op_q[0].push_back(8'h40);
    op_q[1].push_back(8'h00);
    op_q[2].push_back(8'h40);
    drive_done(100);
    n_checks++; if (got_q.size() != 3) begin n_errors++; $display("FAIL zero_count: got %0d want 3", got_q.size()); end
    if (got_q.size() == 3) begin
      n_checks++; if (got_q[0] !== {1'b0, 2'd0, 8'h08}) begin n_errors++; $display("FAIL zero_first: got %0h want %0h", got_q[0], {1'b0, 2'd0, 8'h08}); end
      n_checks++; if (got_q[1] !== {1'b1, 2'd1, SAT}) begin n_errors++; $display("FAIL zero_sat: got %0h want %0h", got_q[1], {1'b1, 2'd1, SAT}); end
      n_checks++; if (got_q[2] !== {1'b0, 2'd2, 8'h08}) begin n_errors++; $display("FAIL zero_last: got %0h want %0h", got_q[2], {1'b0, 2'd2, 8'h08}); end
    end
  endtask

  task automatic test_reset_mid_flight();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 3; i++) op_q[i].push_back(8'h40);
    for (int n = 0; n < 20 && !bus.res_valid; n++) drive_step();
    n_checks++; if (bus.res_valid !== 1'b1) begin n_errors++; $display("FAIL rst_mid_setup: res_valid %0b want 1", bus.res_valid); end
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %0b want 0", bus.res_valid); end
    n_checks++; if ({bus.res_err, bus.res_tag, bus.res_data} !== '0) begin
      n_errors++; $display("FAIL rst_mid_res: got %0h want 0", {bus.res_err, bus.res_tag, bus.res_data});
    end
    n_checks++; if (core_ce !== 1'b0 || bus.req_ready !== '0) begin
      n_errors++; $display("FAIL rst_mid_ce_ready: ce %0b ready %b want 0", core_ce, bus.req_ready);
    end
    bus.req_valid = '0;
    clear_tb_state();
    @(posedge clk); #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rst_mid_ghost: res_valid seen %0d cycles want 0", seen); end
    op_q[3].push_back(8'h10);
    drive_done(50);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== {1'b0, 2'd3, 8'h10}) begin
      n_errors++; $display("FAIL rst_mid_after: got %0d results first %0h want 1 x %0h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {1'b0, 2'd3, 8'h10});
    end
  endtask

  task automatic test_idle_bubbles();
    do_reset();
    gap[3] = 3;
    repeat (5) op_q[3].push_back(8'h40);
    drive_done(100);
    n_checks++; if (got_q.size() != 5) begin n_errors++; $display("FAIL bubble_count: got %0d want 5", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== {1'b0, 2'd3, 8'h08}) begin n_errors++; $display("FAIL bubble_result[%0d]: got %0h want %0h", k, got_q[k], {1'b0, 2'd3, 8'h08}); end
      if (k > 0) begin
        n_checks++; if (got_cyc_q[k] - got_cyc_q[k-1] != 3) begin
          n_errors++; $display("FAIL bubble_spacing[%0d]: got %0d want 3", k, got_cyc_q[k] - got_cyc_q[k-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int ptr = 0;
    int want;
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < NREQ; i++) begin
      gap[i] = $urandom_range(1, 3);
      repeat ($urandom_range(3, 8))
        op_q[i].push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
    end
    drive_done(2000);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL rand_result[%0d]: got %0h want %0h", k, got_q[k], exp_q[k]); end
    end
    for (int k = 0; k < gnt_q.size(); k++) begin
      want = -1;
      for (int o = 0; o < NREQ && want < 0; o++)
        if (gvec_q[k][(ptr + o) % NREQ]) want = (ptr + o) % NREQ;
      n_checks++; if (gnt_q[k] != want) begin n_errors++; $display("FAIL rand_grant[%0d]: got %0d want %0d", k, gnt_q[k], want); end
      ptr = (gnt_q[k] + 1) % NREQ;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    clear_tb_state();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_zero_operand();
    test_reset_mid_flight();
    test_idle_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
